card_dealer: RTL

//  Card source for the baccarat datapath: produces 4-bit card ranks (1=A..13=K, 0=blank) that are

---
 rtl/card_pkg.sv | 15 +
 rtl/card_dealer_rank_counter.sv | 17 +
 rtl/card_dealer.sv | 86 ++++++++
 3 files changed

// File: rtl/card_pkg.sv
// Shared rank types, constants and the 13->1 wrap helper for the card dealer.
package card_pkg;
  typedef logic [3:0] rank_t;

  localparam rank_t RANK_BLANK = 4'd0;
  localparam rank_t RANK_A     = 4'd1;
  localparam rank_t RANK_K     = 4'd13;
  localparam int    NUM_RANKS  = 13;

  typedef enum logic {IDLE, SEARCH} dealer_state_t;

  function automatic rank_t next_rank(input rank_t r);
    return (r == RANK_K) ? RANK_A : rank_t'(r + 4'd1);
  endfunction
endpackage

// File: rtl/card_dealer_rank_counter.sv
// Free-running rank source cycling A..K; the phase at request time is the pseudo-random pick.
module rank_counter
  import card_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  output rank_t rank
);
  rank_t rank_q;

  always_ff @(posedge clk) begin
    if (reset) rank_q <= RANK_A;
    else       rank_q <= next_rank(rank_q);
  end

  assign rank = rank_q;
endmodule

// File: rtl/card_dealer.sv
// Finite-shoe card dealer: picks a start rank from the counter and walks forward past empty ranks.
module card_dealer
  import card_pkg::*;
#(
  parameter int DECKS = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              deal_req,
  input  logic                              shuffle,
  output logic                              ready,
  output logic                              card_valid,
  output logic [3:0]                        card_out,
  output logic [$clog2(52*DECKS+1)-1:0]     cards_left,
  output logic                              shoe_empty
);
  localparam int LW = $clog2(52*DECKS+1);
  localparam int RW = $clog2(4*DECKS+1);
  localparam logic [LW-1:0] LEFT_FULL   = LW'(52*DECKS);
  localparam logic [LW-1:0] LEFT_ONE    = LW'(1);
  localparam logic [RW-1:0] REMAIN_FULL = RW'(4*DECKS);
  localparam logic [RW-1:0] REMAIN_ONE  = RW'(1);

  dealer_state_t   state_q;
  rank_t           cand_q;
  rank_t           card_out_q;
  logic            card_valid_q;
  logic [LW-1:0]   cards_left_q;
  logic [RW-1:0]   remain_q [1:NUM_RANKS];
  rank_t           rank_cnt;

  rank_counter u_rank_counter (
    .clk   (clk),
    .reset (reset),
    .rank  (rank_cnt)
  );

  always_ff @(posedge clk) begin
    card_valid_q <= 1'b0;
    if (reset) begin
      state_q      <= IDLE;
      cand_q       <= RANK_A;
      card_out_q   <= RANK_BLANK;
      cards_left_q <= LEFT_FULL;
      for (int r = 1; r <= NUM_RANKS; r++) remain_q[r] <= REMAIN_FULL;
    end else if (shuffle) begin
      // Reload aborts any search; the last shown card stays on the display.
      state_q      <= IDLE;
      cards_left_q <= LEFT_FULL;
      for (int r = 1; r <= NUM_RANKS; r++) remain_q[r] <= REMAIN_FULL;
    end else begin
      case (state_q)
        IDLE: begin
          if (deal_req) begin
            if (cards_left_q != '0) begin
              cand_q  <= rank_cnt;
              state_q <= SEARCH;
            end else begin
              card_out_q   <= RANK_BLANK;
              card_valid_q <= 1'b1;
            end
          end
        end
        SEARCH: begin
          // A non-empty shoe guarantees this walk hits a stocked rank within 13 steps.
          if (remain_q[cand_q] != '0) begin
            remain_q[cand_q] <= remain_q[cand_q] - REMAIN_ONE;
            cards_left_q     <= cards_left_q - LEFT_ONE;
            card_out_q       <= cand_q;
            card_valid_q     <= 1'b1;
            state_q          <= IDLE;
          end else begin
            cand_q <= next_rank(cand_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready      = (state_q == IDLE) && !shuffle;
  assign card_valid = card_valid_q;
  assign card_out   = card_out_q;
  assign cards_left = cards_left_q;
  assign shoe_empty = (cards_left_q == '0);
endmodule
